// File: rtl/mem_access_pkg.sv
// Shared types and default constants for the memory access blocks (read and write side).
package mem_access_pkg;

    localparam int          DEF_DATA_W       = 32;
    localparam int          DEF_ADDR_W       = 32;
    localparam logic [31:0] DEF_BASE_ADDR    = 32'h1000_0000;
    localparam int          DEF_BURST_WORDS  = 4;
    localparam logic [31:0] DEF_WINDOW_BYTES = 32'h0000_0100;
    localparam int          DEF_TIMEOUT_CYC  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GO     = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } access_state_e;

    function automatic int burst_bytes(input int words, input int data_w);
        return words * data_w / 8;
    endfunction

endpackage

// File: rtl/mem_read_access_if.sv
// Control and user-buffer signals between the read sequencer (master) and the read master core (slave).
// Handshake: the core asserts master_user_data_available while its FIFO head is valid; the
// sequencer pops that head by holding master_user_read_buffer high for one clk, one word per high cycle.
interface mem_read_access_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              master_ctrl_fixed_location;
    logic [ADDR_W-1:0] master_ctrl_read_base;
    logic [ADDR_W-1:0] master_ctrl_read_length;
    logic              master_ctrl_go;
    logic              master_ctrl_done;
    logic              master_user_read_buffer;
    logic [DATA_W-1:0] master_user_buffer_output_data;
    logic              master_user_data_available;

    modport master (
        output master_ctrl_fixed_location,
        output master_ctrl_read_base,
        output master_ctrl_read_length,
        output master_ctrl_go,
        input  master_ctrl_done,
        output master_user_read_buffer,
        input  master_user_buffer_output_data,
        input  master_user_data_available
    );

    modport slave (
        input  master_ctrl_fixed_location,
        input  master_ctrl_read_base,
        input  master_ctrl_read_length,
        input  master_ctrl_go,
        output master_ctrl_done,
        input  master_user_read_buffer,
        output master_user_buffer_output_data,
        output master_user_data_available
    );

endinterface

// File: rtl/but_edge_sync.sv
// Two-flop synchronizer for an asynchronous button, with a one-cycle pulse on its rising edge.
module but_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign rise_pulse = sync_2 & ~sync_prev;

endmodule

// File: rtl/mem_read_access.sv
// Button-triggered burst reader: starts a read master transfer, drains its FIFO,
// sums the words and steps the read base through a wrapping address window.
module mem_read_access
    import mem_access_pkg::*;
#(
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DEF_BASE_ADDR),
    parameter int                BURST_WORDS  = DEF_BURST_WORDS,
    parameter logic [ADDR_W-1:0] WINDOW_BYTES = ADDR_W'(DEF_WINDOW_BYTES),
    parameter int                TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 but0,
    mem_read_access_if.master    bus,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic [DATA_W-1:0]    rd_sum,
    output logic [3:0]           led,
    output access_state_e        state_dbg
);

    localparam logic [ADDR_W-1:0] READ_LEN     = ADDR_W'(burst_bytes(BURST_WORDS, DATA_W));
    localparam logic [ADDR_W-1:0] WIN_END      = BASE_ADDR + WINDOW_BYTES;
    localparam int                WC_W         = $clog2(BURST_WORDS + 1);
    localparam int                TC_W         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WC_W-1:0]   BURST_CNT    = WC_W'(BURST_WORDS);
    localparam logic [TC_W-1:0]   TIMEOUT_LAST = TC_W'(TIMEOUT_CYC - 1);

    access_state_e      state;
    logic [ADDR_W-1:0]  read_base;
    logic [ADDR_W-1:0]  next_base;
    logic               go;
    logic [WC_W-1:0]    word_cnt;
    logic [TC_W-1:0]    cyc_cnt;
    logic [DATA_W-1:0]  sum;
    logic               done_seen;
    logic               done_lat;
    logic               err_lat;
    logic               start_pulse;
    logic               pop;
    logic               burst_full;
    logic               stray_data;

    but_edge_sync u_but_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .async_in   (but0),
        .rise_pulse (start_pulse)
    );

    assign burst_full = (word_cnt == BURST_CNT);
    assign pop        = (state == ST_DRAIN) && bus.master_user_data_available && (word_cnt < BURST_CNT);
    // Data offered when nothing should be outstanding means the core and sequencer disagree.
    assign stray_data = bus.master_user_data_available && ((state == ST_IDLE) || burst_full);
    assign next_base  = read_base + READ_LEN;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            read_base <= BASE_ADDR;
            go        <= 1'b0;
            word_cnt  <= '0;
            cyc_cnt   <= '0;
            sum       <= '0;
            done_seen <= 1'b0;
            done_lat  <= 1'b0;
            err_lat   <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_sum    <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data  <= bus.master_user_buffer_output_data;
                word_cnt <= word_cnt + 1'b1;
                sum      <= sum + bus.master_user_buffer_output_data;
            end
            if (stray_data) begin
                err_lat <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state     <= ST_GO;
                        go        <= 1'b1;
                        word_cnt  <= '0;
                        sum       <= '0;
                        done_seen <= 1'b0;
                        done_lat  <= 1'b0;
                        err_lat   <= 1'b0;
                    end
                end
                ST_GO: begin
                    go      <= 1'b0;
                    cyc_cnt <= '0;
                    state   <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // done may precede the last pop, so it is held until the burst is complete.
                    if (bus.master_ctrl_done) begin
                        done_seen <= 1'b1;
                    end
                    cyc_cnt <= cyc_cnt + 1'b1;
                    if (burst_full && (done_seen || bus.master_ctrl_done)) begin
                        state <= ST_FINISH;
                    end else if (cyc_cnt == TIMEOUT_LAST) begin
                        err_lat <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_FINISH: begin
                    rd_sum    <= sum;
                    done_lat  <= 1'b1;
                    read_base <= (next_base >= WIN_END) ? BASE_ADDR : next_base;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.master_ctrl_fixed_location = 1'b0;
    assign bus.master_ctrl_read_base      = read_base;
    assign bus.master_ctrl_read_length    = READ_LEN;
    assign bus.master_ctrl_go             = go;
    assign bus.master_user_read_buffer    = pop;

    assign led       = {rd_data[0], err_lat, done_lat, (state != ST_IDLE)};
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_read_access.sv
// Directed bench for mem_read_access: a small read-master model, a word scoreboard and hand-computed checks.
module tb_mem_read_access;
    import mem_access_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              but0 = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_sum;
    logic [3:0]        led;
    access_state_e     state_dbg;

    mem_read_access_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_read_access #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .BASE_ADDR    (32'h1000_0000),
        .BURST_WORDS  (4),
        .WINDOW_BYTES (32'h0000_0100),
        .TIMEOUT_CYC  (1024)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .but0      (but0),
        .bus       (bus.master),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_sum    (rd_sum),
        .led       (led),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check / scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- read master model ----------------
    logic [DATA_W-1:0] mdl_words[$];
    logic [DATA_W-1:0] mdl_fifo[$];
    int  mdl_gap = 0;
    int  mdl_first = 0;
    int  mdl_done_mode = 0;   // 0: done after last pop, 1: done right after go, 2: never answer
    bit  mdl_stray = 1'b0;
    bit  pop_pend = 1'b0;
    bit  done_req = 1'b0;
    int  gap_cnt = 0;

    initial begin
        bus.master_ctrl_done               = 1'b0;
        bus.master_user_data_available     = 1'b0;
        bus.master_user_buffer_output_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mdl_fifo.delete();
                pop_pend = 1'b0;
                done_req = 1'b0;
                gap_cnt  = 0;
            end else if (pop_pend) begin
                if (mdl_fifo.size() > 0) void'(mdl_fifo.pop_front());
                gap_cnt = mdl_gap;
                if (mdl_fifo.size() == 0 && mdl_done_mode == 0) done_req = 1'b1;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            bus.master_ctrl_done = done_req;
            done_req = 1'b0;
            bus.master_user_data_available = mdl_stray || (mdl_fifo.size() > 0 && gap_cnt == 0);
            bus.master_user_buffer_output_data = (mdl_fifo.size() > 0) ? mdl_fifo[0] : '0;
            #1;
            pop_pend = bus.master_user_read_buffer;
            if (bus.master_ctrl_go) begin
                mdl_fifo = mdl_words;
                gap_cnt  = mdl_first;
                if (mdl_done_mode == 1) done_req = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    int go_cnt = 0;
    int valid_cnt = 0;
    int drain_cyc = 0;
    int pop_bad = 0;
    int base_moves = 0;
    logic [ADDR_W-1:0] go_base = '0;
    logic [ADDR_W-1:0] go_len = '0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.master_ctrl_go) begin
                go_cnt++;
                go_base = bus.master_ctrl_read_base;
                go_len  = bus.master_ctrl_read_length;
            end
            if (state_dbg != ST_IDLE && bus.master_ctrl_read_base !== go_base) base_moves++;
            if (state_dbg == ST_DRAIN) drain_cyc++;
            if (bus.master_user_read_buffer && !bus.master_user_data_available) pop_bad++;
            if (rd_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) check("sb_extra_word", 64'(exp_q.size()), 64'd1);
                else check("sb_rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic press();
        but0 = 1'b1;
        repeat (4) tick();
        but0 = 1'b0;
    endtask

    task automatic run_txn(input int done_mode, input int gap, input int first, input int probe_at,
                           input bit press_drain, output int go_d, output int val_d);
        int  g0;
        int  v0;
        int  n;
        bit  ok;
        g0 = go_cnt;
        v0 = valid_cnt;
        mdl_done_mode = done_mode;
        mdl_gap       = gap;
        mdl_first     = first;
        foreach (mdl_words[i]) exp_q.push_back(mdl_words[i]);
        press();
        n = 0;
        while (go_cnt == g0 && n < 20) begin tick(); n++; end
        if (probe_at > 0) begin
            repeat (probe_at) tick();
            check("drain_hold_state", state_dbg, ST_DRAIN);
            check("drain_hold_no_pop", 64'(valid_cnt - v0), 64'd0);
        end
        if (press_drain) press();
        n = 0;
        while (!(go_cnt > g0 && state_dbg == ST_IDLE) && n < 3000) begin tick(); n++; end
        ok = (go_cnt > g0 && state_dbg == ST_IDLE);
        check("txn_reached_idle", ok, 1'b1);
        repeat (8) tick();
        go_d  = go_cnt - g0;
        val_d = valid_cnt - v0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int go_d;
        int val_d;
        int d0;
        logic [DATA_W-1:0] exp_sum;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_base", bus.master_ctrl_read_base, 32'h1000_0000);
        check("rst_go", bus.master_ctrl_go, 1'b0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_sum", rd_sum, 32'd0);
        check("rst_led", led, 4'b0000);
        check("fixed_location", bus.master_ctrl_fixed_location, 1'b0);

        // basic burst 1,2,3,4 then done
        mdl_words = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_txn(0, 0, 0, 0, 1'b0, go_d, val_d);
        check("t1_go_pulses", 64'(go_d), 64'd1);
        check("t1_base", go_base, 32'h1000_0000);
        check("t1_length", go_len, 32'd16);
        check("t1_valid_pulses", 64'(val_d), 64'd4);
        check("t1_rd_sum", rd_sum, 32'd10);
        check("t1_led", led, 4'b0010);

        // done before first word
        mdl_words = '{32'd5, 32'd6, 32'd7, 32'd8};
        run_txn(1, 0, 6, 4, 1'b0, go_d, val_d);
        check("t2_base", go_base, 32'h1000_0010);
        check("t2_valid_pulses", 64'(val_d), 64'd4);
        check("t2_rd_sum", rd_sum, 32'd26);
        check("t2_led", led, 4'b0010);

        // gaps of 3 cycles and a press while draining
        mdl_words = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_txn(0, 3, 3, 0, 1'b1, go_d, val_d);
        check("t3_go_pulses", 64'(go_d), 64'd1);
        check("t3_base", go_base, 32'h1000_0020);
        check("t3_valid_pulses", 64'(val_d), 64'd4);
        check("t3_rd_sum", rd_sum, 32'hAA);

        // data offered while idle: no pop, error latched
        d0 = valid_cnt;
        mdl_stray = 1'b1;
        tick();
        mdl_stray = 1'b0;
        tick();
        check("stray_led", led, 4'b0110);
        check("stray_no_pop", 64'(valid_cnt - d0), 64'd0);
        check("stray_state", state_dbg, ST_IDLE);

        // window wrap over 17 transactions from reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int t = 0; t < 17; t++) begin
            mdl_words.delete();
            for (int k = 1; k <= 4; k++) mdl_words.push_back(DATA_W'(t * 4 + k));
            run_txn(0, 0, 0, 0, 1'b0, go_d, val_d);
            check($sformatf("wrap_base_%0d", t), go_base, 32'h1000_0000 + 32'((t % 16) * 16));
            exp_sum = DATA_W'(16 * t + 10);
            check($sformatf("wrap_sum_%0d", t), rd_sum, exp_sum);
        end

        // read master never answers
        mdl_words.delete();
        d0 = drain_cyc;
        run_txn(2, 0, 0, 0, 1'b0, go_d, val_d);
        check("to_drain_cycles", 64'(drain_cyc - d0), 64'd1024);
        check("to_led", led[2:0], 3'b100);
        check("to_base_kept", bus.master_ctrl_read_base, 32'h1000_0010);
        check("to_sum_kept", rd_sum, 32'd266);
        check("to_no_pop", 64'(val_d), 64'd0);

        // reset asserted mid-DRAIN
        mdl_done_mode = 2;
        press();
        repeat (5) tick();
        check("mid_state_before", state_dbg, ST_DRAIN);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", state_dbg, ST_IDLE);
        check("mid_rst_base", bus.master_ctrl_read_base, 32'h1000_0000);
        check("mid_rst_go", bus.master_ctrl_go, 1'b0);
        check("mid_rst_rd_data", rd_data, 32'd0);
        check("mid_rst_rd_valid", rd_valid, 1'b0);
        check("mid_rst_rd_sum", rd_sum, 32'd0);
        check("mid_rst_led", led, 4'b0000);
        check("mid_rst_pop", bus.master_user_read_buffer, 1'b0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        check("pop_without_available", 64'(pop_bad), 64'd0);
        check("base_stable_in_txn", 64'(base_moves), 64'd0);
        check("sb_words_left", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
